tmp_period_meter: RTL and testbench

//  Downstream of the temperature-sensor phase controller. Measures the clk-cycle period between successive

---
 rtl/tmp_pkg.sv | 19 +
 rtl/tmp_period_meter_if.sv | 20 ++
 rtl/tmp_edge_det.sv | 45 ++++
 rtl/tmp_period_meter.sv | 140 ++++++++++++++
 tb/tb_tmp_period_meter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmp_pkg.sv
// Shared definitions for the temperature-sensor period meter: FSM state
// encoding and default build widths. The phase controller's bench uses
// this package as well.
package tmp_pkg;

    // Default width of the period counter and the output code.
    localparam int TMP_PER_W    = 12;
    // Default log2 of the number of periods averaged into one code.
    localparam int TMP_AVG_LOG2 = 2;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        PUBLISH
    } tmp_state_e;

endpackage

// File: rtl/tmp_period_meter_if.sv
// Result handshake between the period meter (master) and readout logic (slave).
interface tmp_period_meter_if #(
    parameter int PER_W = tmp_pkg::TMP_PER_W
);
    logic [PER_W-1:0] code;
    logic             code_valid;
    logic             code_ready;
    logic             code_sat;
    logic             overrun;

    modport master (
        output code, code_valid, code_sat, overrun,
        input  code_ready
    );

    modport slave (
        input  code, code_valid, code_sat, overrun,
        output code_ready
    );
endinterface

// File: rtl/tmp_edge_det.sv
// Rising-edge detector for the controller's PD phase.
// Build option TMP_PD_DEGLITCH_EN: an edge needs pd high on two consecutive
// samples, so single-cycle pulses are rejected at the cost of one extra
// cycle of latency on every edge. Without it any 0->1 transition counts.
module tmp_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic pd_i,
    output logic pd_edge_o
);

    logic pd_d_q;

`ifdef TMP_PD_DEGLITCH_EN
    logic pd_dd_q;

    // Two-deep pd history for the deglitched edge.
    // NOTE: non-blocking assignments make both stages sample the pre-edge
    // values, giving a true shift register rather than a single wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            pd_d_q  <= 1'b0;
            pd_dd_q <= 1'b0;
        end else begin
            pd_d_q  <= pd_i;
            pd_dd_q <= pd_d_q;
        end
    end

    assign pd_edge_o = pd_i & pd_d_q & ~pd_dd_q;
`else
    // One-deep pd history for the plain edge.
    // NOTE: non-blocking assignment keeps the history one cycle behind pd_i.
    always_ff @(posedge clk) begin
        if (reset) begin
            pd_d_q <= 1'b0;
        end else begin
            pd_d_q <= pd_i;
        end
    end

    assign pd_edge_o = pd_i & ~pd_d_q;
`endif

endmodule

// File: rtl/tmp_period_meter.sv
// Temperature period meter: times the clk-cycle gap between PD rising
// edges, averages 2**AVG_LOG2 gaps and offers the mean on a valid/ready
// handshake. Build option TMP_PD_DEGLITCH_EN (in tmp_edge_det) rejects
// single-cycle PD pulses.
module tmp_period_meter
    import tmp_pkg::*;
#(
    parameter int PER_W    = TMP_PER_W,
    parameter int AVG_LOG2 = TMP_AVG_LOG2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pd,
    tmp_period_meter_if.master bus
);

    localparam int               ACC_W       = PER_W + AVG_LOG2;
    localparam logic [PER_W-1:0] CNT_MAX     = '1;
    localparam logic [PER_W-1:0] CNT_ONE     = PER_W'(1);
    localparam logic [4:0]       LAST_SAMPLE = 5'((1 << AVG_LOG2) - 1);

    tmp_state_e       state_q;
    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] cnt_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [4:0]       samples_q;
    logic             sat_q;
    logic             sample_sat;
    logic [PER_W-1:0] code_q;
    logic             code_valid_q;
    logic             code_sat_q;
    logic             overrun_q;
    logic             pd_edge;

    tmp_edge_det u_edge_det (
        .clk       (clk),
        .reset     (reset),
        .pd_i      (pd),
        .pd_edge_o (pd_edge)
    );

    // Saturating count-up value and the accumulator with the current period added.
    // NOTE: every output is assigned on every pass, so no latch can be inferred.
    always_comb begin
        sample_sat = (cnt_q == CNT_MAX);
        cnt_d      = sample_sat ? CNT_MAX : cnt_q + CNT_ONE;
        acc_d      = acc_q + ACC_W'(cnt_q);
    end

    // Sequencer, period timing, averaging and result handshake in one registered block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            samples_q    <= '0;
            sat_q        <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            code_sat_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // Consumer takes the result; a publish below may re-assert valid.
            if (code_valid_q && bus.code_ready) begin
                code_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end

            if (!enable) begin
                // Abort: drop the partial average, keep any pending result.
                state_q   <= IDLE;
                cnt_q     <= '0;
                acc_q     <= '0;
                samples_q <= '0;
                sat_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        samples_q <= '0;
                        sat_q     <= 1'b0;
                        state_q   <= ARM;
                    end
                    ARM: begin
                        // First edge only starts timing.
                        if (pd_edge) begin
                            cnt_q   <= CNT_ONE;
                            state_q <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (pd_edge) begin
                            cnt_q     <= CNT_ONE;
                            acc_q     <= acc_d;
                            samples_q <= samples_q + 5'd1;
                            sat_q     <= sat_q | sample_sat;
                            if (samples_q == LAST_SAMPLE) begin
                                state_q <= PUBLISH;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    PUBLISH: begin
                        code_q       <= PER_W'(acc_q >> AVG_LOG2);
                        code_sat_q   <= sat_q;
                        code_valid_q <= 1'b1;
                        if (code_valid_q && !bus.code_ready) begin
                            overrun_q <= 1'b1;
                        end
                        // Timing never stops; an edge here is the first sample of the next average.
                        if (pd_edge) begin
                            cnt_q     <= CNT_ONE;
                            acc_q     <= ACC_W'(cnt_q);
                            samples_q <= 5'd1;
                            sat_q     <= sample_sat;
                            state_q   <= (LAST_SAMPLE == 5'd0) ? PUBLISH : MEAS;
                        end else begin
                            cnt_q     <= cnt_d;
                            acc_q     <= '0;
                            samples_q <= '0;
                            sat_q     <= 1'b0;
                            state_q   <= MEAS;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.code_sat   = code_sat_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_tmp_period_meter.sv
// Bench for tmp_period_meter: two instances (PER_W=12 and PER_W=8) share
// clk/reset/enable/pd/ready. The expected codes come from a model that
// finds PD edges in the driven waveform and averages the gaps between them.
module tb_tmp_period_meter;

    localparam int AVG_LOG2 = tmp_pkg::TMP_AVG_LOG2;
    localparam int N_AVG    = 1 << AVG_LOG2;
    localparam int MAX12    = 4095;
    localparam int MAX8     = 255;

    typedef struct packed {
        logic [15:0] code;
        logic        sat;
    } result_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic pd;
    logic ready;

    int errors = 0;
    int checks = 0;

    bit      wave[$];
    result_t obs12[$];
    result_t obs8[$];
    result_t exp12[$];
    result_t exp8[$];

    always #5 clk = ~clk;

    tmp_period_meter_if #(.PER_W(12)) bus ();
    tmp_period_meter_if #(.PER_W(8))  bus8 ();

    assign bus.code_ready  = ready;
    assign bus8.code_ready = ready;

    tmp_period_meter #(.PER_W(12), .AVG_LOG2(AVG_LOG2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pd(pd), .bus(bus)
    );

    tmp_period_meter #(.PER_W(8), .AVG_LOG2(AVG_LOG2)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .pd(pd), .bus(bus8)
    );

    // Record every accepted result.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.code_valid && bus.code_ready)
                obs12.push_back({16'(bus.code), bus.code_sat});
            if (bus8.code_valid && bus8.code_ready)
                obs8.push_back({16'(bus8.code), bus8.code_sat});
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        pd     = 1'b0;
        ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        obs12.delete();
        obs8.delete();
        exp12.delete();
        exp8.delete();
        wave.delete();
    endtask

    task automatic add_zeros(input int n);
        for (int i = 0; i < n; i++) wave.push_back(1'b0);
    endtask

    // PD high for 3 cycles; next rising edge comes 'gap' cycles later.
    task automatic add_pulse(input int gap);
        for (int i = 0; i < gap; i++) wave.push_back(i < 3);
    endtask

    task automatic play();
        foreach (wave[i]) begin
            pd = wave[i];
            @(posedge clk);
            #1;
        end
        pd = 1'b0;
    endtask

    // Reference: edges from the waveform, gaps between edges clipped to the
    // counter maximum, grouped N_AVG at a time, mean rounded down.
    function automatic void model_expected();
        int edges[$];
        int sum12 = 0;
        int sum8  = 0;
        int cnt   = 0;
        bit s12   = 1'b0;
        bit s8    = 1'b0;
        for (int i = 0; i < wave.size(); i++) begin
            bit prev = (i > 0) ? wave[i-1] : 1'b0;
            bit nxt  = (i + 1 < wave.size()) ? wave[i+1] : 1'b0;
`ifdef TMP_PD_DEGLITCH_EN
            if (wave[i] && !prev && nxt) edges.push_back(i);
`else
            if (wave[i] && !prev) edges.push_back(i);
            if (nxt) begin end
`endif
        end
        for (int k = 1; k < edges.size(); k++) begin
            int p = edges[k] - edges[k-1];
            sum12 += (p >= MAX12) ? MAX12 : p;
            sum8  += (p >= MAX8) ? MAX8 : p;
            s12   |= (p >= MAX12);
            s8    |= (p >= MAX8);
            cnt++;
            if (cnt == N_AVG) begin
                exp12.push_back({16'(sum12 / N_AVG), s12});
                exp8.push_back({16'(sum8 / N_AVG), s8});
                sum12 = 0; sum8 = 0; cnt = 0; s12 = 1'b0; s8 = 1'b0;
            end
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; pd = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.code !== 12'd0)     begin errors++; $display("FAIL reset_code: got %0d want 0", bus.code); end
        checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.code_valid); end
        checks++; if (bus.code_sat !== 1'b0)   begin errors++; $display("FAIL reset_sat: got %b want 0", bus.code_sat); end
        checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        checks++; if (bus8.code !== 8'd0 || bus8.code_valid !== 1'b0)
            begin errors++; $display("FAIL reset_inst8: got code %0d valid %b want 0 0", bus8.code, bus8.code_valid); end
    endtask

    task automatic test_clean();
        do_reset();
        enable = 1'b1;
        add_zeros(4);
        for (int i = 0; i < 9; i++) add_pulse(20);
        add_zeros(10);
        model_expected();
        play();
        checks++;
        if (obs12.size() != 2 || obs12[0] !== {16'd20, 1'b0})
            begin errors++; $display("FAIL clean_first: got %0d results, first %0d want 2 results, first 20 sat 0",
                                     obs12.size(), (obs12.size() > 0) ? int'(obs12[0].code) : -1); end
        checks++;
        if (obs12.size() != exp12.size() || obs8.size() != exp8.size())
            begin errors++; $display("FAIL clean_count: got %0d/%0d want %0d/%0d", obs12.size(), obs8.size(), exp12.size(), exp8.size()); end
        foreach (exp12[i]) begin
            checks++;
            if (i >= obs12.size() || i >= obs8.size() || obs12[i] !== exp12[i] || obs8[i] !== exp8[i])
                begin errors++; $display("FAIL clean_code[%0d]: want %0d/%0d", i, exp12[i].code, exp8[i].code); end
        end
    endtask

    task automatic test_averaging();
        int gaps[8] = '{20, 21, 21, 22, 20, 20, 20, 23};
        do_reset();
        enable = 1'b1;
        add_zeros(4);
        foreach (gaps[i]) add_pulse(gaps[i]);
        add_pulse(12);
        model_expected();
        play();
        checks++;
        if (obs12.size() != 2 || obs12[0].code !== 16'd21 || obs12[1].code !== 16'd20)
            begin errors++; $display("FAIL avg_codes: got %0d results want 21 then 20", obs12.size()); end
        foreach (exp12[i]) begin
            checks++;
            if (i >= obs12.size() || i >= obs8.size() || obs12[i] !== exp12[i] || obs8[i] !== exp8[i])
                begin errors++; $display("FAIL avg_code[%0d]: want %0d", i, exp12[i].code); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            enable = 1'b1;
            add_zeros(4);
            for (int i = 0; i < 3 * N_AVG; i++) add_pulse(int'($urandom_range(60, 8)));
            add_pulse(12);
            model_expected();
            play();
            checks++;
            if (obs12.size() != exp12.size() || obs8.size() != exp8.size())
                begin errors++; $display("FAIL rand%0d_count: got %0d/%0d want %0d/%0d", r, obs12.size(), obs8.size(), exp12.size(), exp8.size()); end
            foreach (exp12[i]) begin
                checks++;
                if (i >= obs12.size() || i >= obs8.size() || obs12[i] !== exp12[i] || obs8[i] !== exp8[i])
                    begin errors++; $display("FAIL rand%0d_code[%0d]: want %0d", r, i, exp12[i].code); end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        enable = 1'b1;
        add_zeros(4);
        add_pulse(300);
        for (int i = 0; i < 7; i++) add_pulse(20);
        add_pulse(12);
        model_expected();
        play();
        checks++;
        if (obs8.size() != 2 || obs8[0] !== {16'd78, 1'b1} || obs8[1] !== {16'd20, 1'b0})
            begin errors++; $display("FAIL sat_inst8: got %0d results, first %0d want 78 sat 1 then 20 sat 0",
                                     obs8.size(), (obs8.size() > 0) ? int'(obs8[0].code) : -1); end
        foreach (exp12[i]) begin
            checks++;
            if (i >= obs12.size() || i >= obs8.size() || obs12[i] !== exp12[i] || obs8[i] !== exp8[i])
                begin errors++; $display("FAIL sat_code[%0d]: want %0d/%0d", i, exp12[i].code, exp8[i].code); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready  = 1'b0;
        enable = 1'b1;
        add_zeros(4);
        for (int i = 0; i < 4; i++) add_pulse(20);
        add_pulse(24);
        play();
        @(negedge clk);
        checks++;
        if (bus.code_valid !== 1'b1 || bus.code !== 12'd20 || bus.overrun !== 1'b0)
            begin errors++; $display("FAIL bp_first: got valid %b code %0d ovr %b want 1 20 0", bus.code_valid, bus.code, bus.overrun); end
        @(posedge clk); #1;
        wave.delete();
        for (int i = 0; i < 3; i++) add_pulse(24);
        add_pulse(10);
        add_zeros(6);
        play();
        @(negedge clk);
        checks++;
        if (bus.code_valid !== 1'b1 || bus.code !== 12'd24 || bus.code_sat !== 1'b0)
            begin errors++; $display("FAIL bp_second: got valid %b code %0d want 1 24", bus.code_valid, bus.code); end
        checks++;
        if (bus.overrun !== 1'b1)
            begin errors++; $display("FAIL bp_overrun_set: got %b want 1", bus.overrun); end
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.code_valid !== 1'b0 || bus.overrun !== 1'b0)
            begin errors++; $display("FAIL bp_handshake: got valid %b ovr %b want 0 0", bus.code_valid, bus.overrun); end
        checks++;
        if (obs12.size() != 1 || obs12[0].code !== 16'd24)
            begin errors++; $display("FAIL bp_accepted: got %0d results want one code 24", obs12.size()); end
    endtask

    task automatic test_abort_reset();
        do_reset();
        enable = 1'b1;
        add_zeros(4);
        for (int i = 0; i < 3; i++) add_pulse(20);
        play();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.code_valid !== 1'b0 || obs12.size() != 0)
            begin errors++; $display("FAIL abort_nocode: got valid %b results %0d want 0 0", bus.code_valid, obs12.size()); end
        enable = 1'b1;
        wave.delete();
        add_zeros(40);
        for (int i = 0; i < 5; i++) add_pulse(20);
        add_zeros(6);
        play();
        checks++;
        if (obs12.size() != 1 || obs12[0] !== {16'd20, 1'b0})
            begin errors++; $display("FAIL abort_rearm: got %0d results, first %0d want one code 20",
                                     obs12.size(), (obs12.size() > 0) ? int'(obs12[0].code) : -1); end
        ready = 1'b0;
        wave.delete();
        for (int i = 0; i < 4; i++) add_pulse(20);
        add_zeros(5);
        play();
        @(negedge clk);
        checks++;
        if (bus.code_valid !== 1'b1)
            begin errors++; $display("FAIL abort_pending: got valid %b want 1", bus.code_valid); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.code !== 12'd0 || bus.code_valid !== 1'b0 || bus.code_sat !== 1'b0 || bus.overrun !== 1'b0)
            begin errors++; $display("FAIL midreset: got code %0d valid %b sat %b ovr %b want all 0",
                                     bus.code, bus.code_valid, bus.code_sat, bus.overrun); end
        reset = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        enable = 1'b1;
        add_zeros(4);
        add_pulse(20);
        for (int i = 0; i < 20; i++) wave.push_back(i < 3 || i == 9);
        for (int i = 0; i < 4; i++) add_pulse(20);
        add_zeros(10);
        model_expected();
        play();
        checks++;
`ifdef TMP_PD_DEGLITCH_EN
        if (obs12.size() != 1 || obs12[0].code !== 16'd20)
            begin errors++; $display("FAIL glitch_filtered: got %0d results want one code 20", obs12.size()); end
`else
        if (obs12.size() != 1 || obs12[0].code !== 16'd15)
            begin errors++; $display("FAIL glitch_split: got %0d results want one code 15", obs12.size()); end
`endif
        foreach (exp12[i]) begin
            checks++;
            if (i >= obs12.size() || i >= obs8.size() || obs12[i] !== exp12[i] || obs8[i] !== exp8[i])
                begin errors++; $display("FAIL glitch_code[%0d]: want %0d", i, exp12[i].code); end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_averaging();
        test_random();
        test_saturation();
        test_backpressure();
        test_abort_reset();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
